// File: rtl/program_counter_unit.sv
// Fetch-address register and next-PC selection with a BOOT/RUN/HALT control FSM.
// Define PC_RAS_EN to build the return-address stack; otherwise ret acts as a plain jr.
module program_counter_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [15:0]      br_imm,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_addr,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_addr,
  input  logic             call,
  input  logic             ret,
  input  logic             resume,
  input  logic [WIDTH-1:0] resume_addr,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             pc_valid,
  output logic             halted,
  output logic             misalign,
  output logic             ras_err
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_nxt, target;
  logic             valid_nxt, halted_nxt, misalign_nxt;
  logic             run_adv, trap;
  logic             pop_hit;
  logic [WIDTH-1:0] pop_val;

  function automatic logic [WIDTH-1:0] branch_target(input logic [WIDTH-1:0] base,
                                                     input logic [15:0]      imm);
    logic signed [WIDTH+17:0] ext;
    logic [WIDTH-1:0]         ofs;
    ext = {{(WIDTH+2){imm[15]}}, imm};
    ofs = ext[WIDTH-1:0] << 2;
    return base + ofs;
  endfunction

  assign pc_plus4 = pc_out + WIDTH'(4);
  assign run_adv  = (state == RUN) && !stall;

`ifdef PC_RAS_EN
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [CNT_W-1:0] ras_cnt, ras_cnt_nxt;
  logic             do_push, do_pop, ras_empty, ras_full, ras_evt;

  assign do_push   = run_adv && call;
  assign do_pop    = run_adv && ret;
  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
  assign pop_hit   = do_pop && !ras_empty;
  assign pop_val   = ras[0];
  // Simultaneous call/ret replaces the top in place; the pop has already read it.
  assign ras_evt   = (do_pop && ras_empty) || (do_push && !do_pop && ras_full);

  always_comb begin
    ras_cnt_nxt = ras_cnt;
    if (do_push && do_pop) begin
      if (ras_empty) ras_cnt_nxt = CNT_W'(1);
    end else if (do_push) begin
      if (!ras_full) ras_cnt_nxt = ras_cnt + CNT_W'(1);
    end else if (do_pop) begin
      if (!ras_empty) ras_cnt_nxt = ras_cnt - CNT_W'(1);
    end
  end

  // Entry 0 is the top; a push on a full stack shifts the oldest entry out the bottom.
  always_ff @(posedge clk) begin
    if (do_push && do_pop) begin
      ras[0] <= pc_plus4;
    end else if (do_push) begin
      for (int i = RAS_DEPTH - 1; i > 0; i--) ras[i] <= ras[i-1];
      ras[0] <= pc_plus4;
    end else if (do_pop) begin
      for (int i = 0; i < RAS_DEPTH - 1; i++) ras[i] <= ras[i+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_cnt <= '0;
      ras_err <= 1'b0;
    end else begin
      ras_cnt <= ras_cnt_nxt;
      ras_err <= ras_err | ras_evt;
    end
  end
`else
  logic unused_ras;
  assign unused_ras = call ^ (RAS_DEPTH > 0);
  assign pop_hit    = 1'b0;
  assign pop_val    = '0;
  assign ras_err    = 1'b0;
`endif

  always_comb begin
    if (jr || ret)    target = pop_hit ? pop_val : jr_addr;
    else if (jmp)     target = jmp_addr;
    else if (br_taken) target = branch_target(pc_plus4, br_imm);
    else              target = pc_plus4;
  end

  // A misaligned current PC (from a resume) traps as well as a misaligned target.
  assign trap = (target[1:0] != 2'b00) || (pc_out[1:0] != 2'b00);

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_out;
    valid_nxt    = pc_valid;
    halted_nxt   = halted;
    misalign_nxt = misalign;
    unique case (state)
      BOOT: begin
        state_nxt = RUN;
        valid_nxt = 1'b1;
      end
      RUN: begin
        if (!stall) begin
          if (trap) begin
            state_nxt    = HALT;
            valid_nxt    = 1'b0;
            halted_nxt   = 1'b1;
            misalign_nxt = 1'b1;
          end else begin
            pc_nxt = target;
          end
        end
      end
      HALT: begin
        if (!stall && resume) begin
          state_nxt    = RUN;
          pc_nxt       = resume_addr;
          valid_nxt    = 1'b1;
          halted_nxt   = 1'b0;
          misalign_nxt = 1'b0;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc_out   <= RESET_VECTOR;
      pc_valid <= 1'b0;
      halted   <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc_out   <= pc_nxt;
      pc_valid <= valid_nxt;
      halted   <= halted_nxt;
      misalign <= misalign_nxt;
    end
  end

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed and randomized bench for program_counter_unit against a queue-based reference model.
module tb_program_counter_unit;

  localparam int RAS_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_taken, jmp, jr, call, ret, resume;
  logic [15:0] br_imm;
  logic [31:0] jmp_addr, jr_addr, resume_addr;
  logic [31:0] pc_out, pc_plus4;
  logic        pc_valid, halted, misalign, ras_err;

  program_counter_unit #(
    .WIDTH(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .br_imm(br_imm),
    .jmp(jmp), .jmp_addr(jmp_addr), .jr(jr), .jr_addr(jr_addr), .call(call), .ret(ret),
    .resume(resume), .resume_addr(resume_addr), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .pc_valid(pc_valid), .halted(halted), .misalign(misalign), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_booted;
  logic [31:0] m_pc;
  bit          m_valid, m_halted, m_mis, m_rase;
  logic [31:0] m_ras[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_booted = 0; m_pc = 32'h0; m_valid = 0; m_halted = 0; m_mis = 0; m_rase = 0;
    m_ras.delete();
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    logic [31:0] seq;
    bit          popped;
    logic [31:0] pval;
    seq    = m_pc + 32'd4;
    popped = 0;
    pval   = 32'h0;
    if (!m_booted) begin
      m_booted = 1; m_valid = 1;
    end else if (stall) begin
    end else if (m_halted) begin
      if (resume) begin
        m_pc = resume_addr; m_mis = 0; m_valid = 1; m_halted = 0;
      end
    end else begin
`ifdef PC_RAS_EN
      if (ret) begin
        if (m_ras.size() > 0) begin popped = 1; pval = m_ras.pop_back(); end
        else m_rase = 1;
      end
      if (call) begin
        m_ras.push_back(seq);
        if (m_ras.size() > RAS_DEPTH) begin void'(m_ras.pop_front()); m_rase = 1; end
      end
`endif
      if (jr || ret)     tgt = popped ? pval : jr_addr;
      else if (jmp)      tgt = jmp_addr;
      else if (br_taken) tgt = seq + 32'(int'($signed(br_imm)) * 4);
      else               tgt = seq;
      if ((m_pc % 4) != 0 || (tgt % 4) != 0) begin
        m_halted = 1; m_mis = 1; m_valid = 0;
      end else begin
        m_pc = tgt;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".pc"},     pc_out,   m_pc);
    check_eq({tag, ".pc4"},    pc_plus4, m_pc + 32'd4);
    check_eq({tag, ".valid"},  32'(pc_valid), 32'(m_valid));
    check_eq({tag, ".halted"}, 32'(halted),   32'(m_halted));
    check_eq({tag, ".mis"},    32'(misalign), 32'(m_mis));
    check_eq({tag, ".rase"},   32'(ras_err),  32'(m_rase));
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic clear_inputs();
    stall = 0; br_taken = 0; br_imm = 16'h0; jmp = 0; jmp_addr = 32'h0;
    jr = 0; jr_addr = 32'h0; call = 0; ret = 0; resume = 0; resume_addr = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    #1;
    check_all("rst");
    @(negedge clk);
    rst_n = 1;
  endtask

  function automatic logic [31:0] rand_addr(input int mis_pct);
    logic [31:0] a;
    a = {16'h0, $urandom_range(0, 16'hFFFF)} & 32'hFFFF_FFFC;
    if ($urandom_range(0, 99) < mis_pct) a = a + 32'd2;
    return a;
  endfunction

  initial begin
    rst_n = 0;
    clear_inputs();
    model_reset();
    #12;
    check_all("rst0");
    check_eq("t1_valid0", 32'(pc_valid), 32'h0);
    @(negedge clk);
    rst_n = 1;

    // Boot and sequential run
    step("boot");
    check_eq("t1_valid1", 32'(pc_valid), 32'h1);
    check_eq("t1_pc0", pc_out, 32'h0);
    step("seq1"); check_eq("t1_pc4", pc_out, 32'h4);
    step("seq2"); check_eq("t1_pc8", pc_out, 32'h8);
    step("seq3"); check_eq("t1_pcC", pc_out, 32'hC);
    step("seq4");

    // Backward branch, first stalled then taken
    br_taken = 1; br_imm = 16'hFFFE; stall = 1;
    step("br_stall"); check_eq("t2_stall", pc_out, 32'h10);
    stall = 0;
    step("br"); check_eq("t2_br", pc_out, 32'h0C);
    clear_inputs();

    // Priority jr > jmp > branch
    jr = 1; jr_addr = 32'h40; jmp = 1; jmp_addr = 32'h80; br_taken = 1; br_imm = 16'h0010;
    step("prio"); check_eq("t3_prio", pc_out, 32'h40);
    clear_inputs();

    // Misaligned trap, redirects ignored in HALT, resume
    jr = 1; jr_addr = 32'h42;
    step("trap");
    check_eq("t4_halt", 32'(halted), 32'h1);
    check_eq("t4_hold", pc_out, 32'h40);
    clear_inputs();
    jmp = 1; jmp_addr = 32'h200;
    step("halt_ign"); check_eq("t4_ign", pc_out, 32'h40);
    clear_inputs();
    resume = 1; resume_addr = 32'h100;
    step("resume");
    check_eq("t4_res", pc_out, 32'h100);
    check_eq("t4_misclr", 32'(misalign), 32'h0);
    resume_addr = 32'h300;
    step("res_ign"); check_eq("t4_resign", pc_out, 32'h104);
    clear_inputs();

    // Wrap-around and asynchronous mid-cycle reset
    jmp = 1; jmp_addr = 32'hFFFF_FFFC;
    step("wrap_j");
    jmp = 0;
    step("wrap"); check_eq("t5_wrap", pc_out, 32'h0);
    jmp = 1; jmp_addr = 32'h400;
    step("pre_rst");
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check_eq("t5_arst", pc_out, 32'h0);
    check_all("arst");
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    step("boot2");

    // Five calls then five returns
    for (int i = 0; i < 5; i++) begin
      call = 1; jmp = 1; jmp_addr = 32'h1000 * (i + 1);
      step("call");
    end
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      ret = 1; jr_addr = 32'h2000;
      step("ret");
`ifdef PC_RAS_EN
      if (i == 0) check_eq("t6_ret0", pc_out, 32'h4004);
      if (i == 3) check_eq("t6_ret3", pc_out, 32'h1004);
`endif
    end
    check_eq("t6_ret4", pc_out, 32'h2000);
`ifdef PC_RAS_EN
    check_eq("t6_rase", 32'(ras_err), 32'h1);
`endif
    clear_inputs();

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      stall       = ($urandom_range(0, 4) == 0);
      br_taken    = ($urandom_range(0, 3) == 0);
      br_imm      = 16'($urandom_range(0, 63)) - 16'd32;
      jmp         = ($urandom_range(0, 7) == 0);
      jmp_addr    = rand_addr(5);
      jr          = ($urandom_range(0, 9) == 0);
      jr_addr     = rand_addr(5);
      call        = ($urandom_range(0, 5) == 0);
      ret         = ($urandom_range(0, 7) == 0);
      resume      = ($urandom_range(0, 2) == 0);
      resume_addr = rand_addr(10);
      step("rnd");
      if (n == 300) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
